// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war match controller.
package tow_pkg;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        OVER  = 2'd2
    } tow_state_t;

    localparam int DEFAULT_MAX_SCORE    = 7;
    localparam int DEFAULT_SERVE_CYCLES = 4;
    localparam int DEFAULT_LFSR_W       = 10;
    localparam int DEFAULT_DIFF_W       = 9;

    // x^10 + x^7 + 1 taps on bits 9 and 6 of a shift-left register
    localparam logic [9:0] LFSR_TAPS_10 = 10'h240;

    // Maximal-length Fibonacci tap masks; unknown widths fall back to the 10-bit mask
    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] taps;
        case (width)
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            7:       taps = 32'h0000_0060;
            9:       taps = 32'h0000_0110;
            11:      taps = 32'h0000_0500;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_D008;
            default: taps = {22'd0, LFSR_TAPS_10};
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/tow_lfsr.sv
// Free-running Fibonacci LFSR used as the computer player's random source.
module tow_lfsr
    import tow_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_LFSR_W,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_10,
    parameter logic [WIDTH-1:0] SEED  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            value <= SEED;
        end else if (enable) begin
            value <= {value[WIDTH-2:0], ^(value & TAPS)};
        end
    end

endmodule

// File: rtl/tow_match_ctrl.sv
// Match sequencer: serves the playfield, forwards presses, keeps score, ends the match.
module tow_match_ctrl
    import tow_pkg::*;
#(
    parameter int MAX_SCORE    = DEFAULT_MAX_SCORE,
    parameter int SERVE_CYCLES = DEFAULT_SERVE_CYCLES,
    parameter int LFSR_W       = DEFAULT_LFSR_W,
    parameter int DIFF_W       = DEFAULT_DIFF_W
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             human_press,
    input  logic [DIFF_W-1:0]                difficulty,
    input  logic                             wL,
    input  logic                             wR,
    output logic                             field_reset,
    output logic                             pL,
    output logic                             pR,
    output logic [$clog2(MAX_SCORE+1)-1:0]   score_l,
    output logic [$clog2(MAX_SCORE+1)-1:0]   score_r,
    output logic                             match_over,
    output logic                             winner
);

    localparam int SCORE_W = $clog2(MAX_SCORE + 1);
    localparam int CNT_W   = $clog2(SERVE_CYCLES + 1);

    localparam logic [SCORE_W-1:0] SCORE_MAX  = SCORE_W'(MAX_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_LAST = SCORE_W'(MAX_SCORE - 1);
    localparam logic [CNT_W-1:0]   SERVE_MAX  = CNT_W'(SERVE_CYCLES);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_CYCLES - 1);
    localparam logic [31:0]        TAPS_ALL   = lfsr_taps(LFSR_W);

    tow_state_t        state;
    logic [CNT_W-1:0]  serve_cnt;
    logic [LFSR_W-1:0] lfsr;
    logic              cpu_hit;

    tow_lfsr #(
        .WIDTH (LFSR_W),
        .TAPS  (TAPS_ALL[LFSR_W-1:0]),
        .SEED  (LFSR_W'(1))
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (1'b1),
        .value   (lfsr)
    );

    // Comparing the shifted full state equals comparing its top DIFF_W bits
    assign cpu_hit = (lfsr >> (LFSR_W - DIFF_W)) < LFSR_W'(difficulty);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= SERVE;
            serve_cnt   <= '0;
            field_reset <= 1'b1;
            pL          <= 1'b0;
            pR          <= 1'b0;
            score_l     <= '0;
            score_r     <= '0;
            match_over  <= 1'b0;
            winner      <= 1'b0;
        end else begin
            case (state)
                SERVE: begin
                    field_reset <= 1'b1;
                    pL          <= 1'b0;
                    pR          <= 1'b0;
                    if (serve_cnt != SERVE_MAX) begin
                        serve_cnt <= serve_cnt + 1'b1;
                    end
                    if (serve_cnt >= SERVE_LAST) begin
                        state       <= PLAY;
                        field_reset <= 1'b0;
                    end
                end

                PLAY: begin
                    if (wL || wR) begin
                        field_reset <= 1'b1;
                        pL          <= 1'b0;
                        pR          <= 1'b0;
                        serve_cnt   <= '0;
                        state       <= SERVE;
                        // A tied rally falls through both branches and simply re-serves
                        if (wL && !wR) begin
                            if (score_l != SCORE_MAX) begin
                                score_l <= score_l + 1'b1;
                            end
                            if (score_l == SCORE_LAST) begin
                                state      <= OVER;
                                match_over <= 1'b1;
                                winner     <= 1'b1;
                            end
                        end else if (wR && !wL) begin
                            if (score_r != SCORE_MAX) begin
                                score_r <= score_r + 1'b1;
                            end
                            if (score_r == SCORE_LAST) begin
                                state      <= OVER;
                                match_over <= 1'b1;
                                winner     <= 1'b0;
                            end
                        end
                    end else begin
                        field_reset <= 1'b0;
                        pL          <= human_press;
                        pR          <= cpu_hit;
                    end
                end

                OVER: begin
                    field_reset <= 1'b1;
                    pL          <= 1'b0;
                    pR          <= 1'b0;
                    match_over  <= 1'b1;
                end

                default: begin
                    state       <= SERVE;
                    serve_cnt   <= '0;
                    field_reset <= 1'b1;
                    pL          <= 1'b0;
                    pR          <= 1'b0;
                end
            endcase
        end
    end

endmodule
